mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one single-ported, wait-state memory bus between the instruction-fetch
//  port (IF, read-only) and the data port (MEM stage, read/write).
//  Sits between the core's rom/ram interfaces and the external bus.
//  Raises per-port stall requests toward ctrl until each access completes.
// PARAMETERS
//  AW        32   address width
//  DW        32   data width (sel width = DW/8)
//  MAX_WAIT  255  max bus cycles to wait for m_ack before abort (>=1)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, asynchronous, active-low
//  if_req       in   1      fetch request; held until if_ready
//  if_addr      in   AW     fetch address
//  if_rdata     out  DW     fetch read data, valid while if_ready=1
//  if_ready     out  1      one-cycle fetch-complete pulse
//  d_req        in   1      data request; held until d_ready
//  d_we         in   1      1=write, 0=read
//  d_sel        in   DW/8   byte lane enables
//  d_addr       in   AW     data address
//  d_wdata      in   DW     write data
//  d_rdata      out  DW     data read data, valid while d_ready=1
//  d_ready      out  1      one-cycle data-complete pulse
//  m_cyc/m_stb  out  1      bus cycle / strobe (always equal)
//  m_we         out  1      bus write enable
//  m_sel        out  DW/8   bus byte enables
//  m_addr       out  AW     bus address
//  m_wdata      out  DW     bus write data
//  m_rdata      in   DW     bus read data, sampled with m_ack
//  m_ack        in   1      bus acknowledge
//  stallreq_if  out  1      = if_req & ~if_ready (combinational)
//  stallreq_d   out  1      = d_req & ~d_ready (combinational)
//  bus_err      out  1      one-cycle pulse on timeout abort
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, last_grant=IF, wait counter 0; all
//    outputs 0 immediately, including m_cyc/m_stb; an in-flight access is
//    dropped with no ready pulse.
//  - FSM: IDLE -> GNT_IF | GNT_D -> IDLE. Transition to IDLE on m_ack or timeout.
//  - Arbitration happens in IDLE only:
//    - Data has priority.
//    - If both are requesting and last_grant==D, IF wins (no starvation).
//    - last_grant updates on every grant.
//  - At grant, latch addr/we/sel/wdata (fetch: we=0, sel=all 1s).
//    m_* outputs come from registers and stay stable for the whole GNT state.
//  - Timing:
//    - Cycle 0: request seen in IDLE.
//    - Cycle 1: GNT with m_stb=1; m_ack may arrive the same cycle.
//    - Cycle after m_ack: *_ready=1, *_rdata=registered m_rdata, state IDLE,
//      m_stb=0.
//    - Minimum 2 cycles from request to ready; at least 1 idle bus cycle
//      between accesses.
//  - Writes: *_rdata=0 on ready.
//  - m_ack outside GNT is ignored.
//  - Request withdrawn mid-access: the access still completes and ready still
//    pulses; the requester ignores it.
//  - Timeout:
//    - The wait counter ($clog2(MAX_WAIT+1) bits) counts GNT cycles without ack.
//    - On reaching MAX_WAIT: drop m_cyc/m_stb, then next cycle pulse bus_err
//      and the owner's ready with rdata=0; return to IDLE.
//    - The counter clears at each grant.
//  - Same-cycle stall/ready: the stall request deasserts in the ready cycle,
//    so the pipeline advances exactly once.
//  - Ready pulses never overlap; only the granted port pulses.
// TESTING
//  1. Reset with d_req=1 mid-GNT_D -> m_stb, stallreqs' sources and ready
//     fall to 0 asynchronously; after release, IDLE.
//  2. if_req only, addr 0x100, m_ack in 1st GNT cycle with 0xDEADBEEF
//     -> if_ready at cycle 2, if_rdata=0xDEADBEEF, stallreq_if high cycles 0-1.
//  3. if_req and d_req together from reset -> D first (last_grant=IF);
//     then IF, even if d_req is re-raised.
//  4. d write, addr 0x40, sel 4'b0011, wdata 0x1234, ack after 3 wait cycles
//     -> m_* stable 4 cycles; d_ready 1 cycle later; d_rdata=0.
//  5. MAX_WAIT=4, no ack -> m_stb drops after 4 GNT cycles; bus_err and
//     if_ready pulse together; rdata=0.
//  6. Spurious m_ack in IDLE -> no ready; request dropped mid-GNT -> ready
//     still pulses once.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the core's fetch/data ports, the arbiter and the external
// wait-state bus. The master view belongs to the arbiter; the slave view belongs to its environment.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;

  logic          d_req;
  logic          d_we;
  logic [SW-1:0] d_sel;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;

  logic          m_cyc;
  logic          m_stb;
  logic          m_we;
  logic [SW-1:0] m_sel;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ack;

  logic          stallreq_if;
  logic          stallreq_d;
  logic          bus_err;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_sel, d_addr, d_wdata, m_rdata, m_ack,
    output if_rdata, if_ready, d_rdata, d_ready,
    output m_cyc, m_stb, m_we, m_sel, m_addr, m_wdata,
    output stallreq_if, stallreq_d, bus_err
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_sel, d_addr, d_wdata, m_rdata, m_ack,
    input  if_rdata, if_ready, d_rdata, d_ready,
    input  m_cyc, m_stb, m_we, m_sel, m_addr, m_wdata,
    input  stallreq_if, stallreq_d, bus_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported wait-state bus between the fetch port and the data port.
// Data wins ties unless it also won the previous grant. A bus watchdog aborts an access that is never acknowledged.
module mem_bus_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 255
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.master bus
);
  localparam int SW = DW / 8;
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D} state_t;
  typedef enum logic {PORT_IF, PORT_D} port_t;

  typedef struct packed {
    logic          we;
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } access_t;

  state_t        state, state_nxt;
  port_t         last_grant, last_grant_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          stb, stb_nxt;
  access_t       acc, acc_nxt;
  logic          if_ready, if_ready_nxt;
  logic          d_ready, d_ready_nxt;
  logic          bus_err, bus_err_nxt;
  logic [DW-1:0] if_rdata, if_rdata_nxt;
  logic [DW-1:0] d_rdata, d_rdata_nxt;
  logic [DW-1:0] rdata_cap;
  logic          if_pend, d_pend, grant_d;

  // A port in its ready cycle is already served and must not be granted again.
  assign if_pend = bus.if_req & ~if_ready;
  assign d_pend  = bus.d_req & ~d_ready;
  assign grant_d = d_pend & ~(if_pend & (last_grant == PORT_D));

  always_comb begin
    // NOTE: every variable gets a default here first, so no path can infer a latch.
    state_nxt      = state;
    last_grant_nxt = last_grant;
    wait_cnt_nxt   = wait_cnt;
    stb_nxt        = stb;
    acc_nxt        = acc;
    if_ready_nxt   = 1'b0;
    d_ready_nxt    = 1'b0;
    bus_err_nxt    = 1'b0;
    if_rdata_nxt   = '0;
    d_rdata_nxt    = '0;
    rdata_cap      = (bus.m_ack && !acc.we) ? bus.m_rdata : '0;

    unique case (state)
      IDLE: begin
        wait_cnt_nxt = '0;
        if (grant_d) begin
          state_nxt      = GNT_D;
          last_grant_nxt = PORT_D;
          stb_nxt        = 1'b1;
          acc_nxt.we     = bus.d_we;
          acc_nxt.sel    = bus.d_sel;
          acc_nxt.addr   = bus.d_addr;
          acc_nxt.wdata  = bus.d_wdata;
        end else if (if_pend) begin
          state_nxt      = GNT_IF;
          last_grant_nxt = PORT_IF;
          stb_nxt        = 1'b1;
          acc_nxt.we     = 1'b0;
          acc_nxt.sel    = '1;
          acc_nxt.addr   = bus.if_addr;
          acc_nxt.wdata  = '0;
        end
      end
      GNT_IF, GNT_D: begin
        // Ack and timeout both close the access; only a timeout raises bus_err.
        if (bus.m_ack || (wait_cnt == WAIT_LAST)) begin
          state_nxt    = IDLE;
          stb_nxt      = 1'b0;
          bus_err_nxt  = ~bus.m_ack;
          wait_cnt_nxt = wait_cnt + 1'b1;
          if (state == GNT_IF) begin
            if_ready_nxt = 1'b1;
            if_rdata_nxt = rdata_cap;
          end else begin
            d_ready_nxt = 1'b1;
            d_rdata_nxt = rdata_cap;
          end
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        stb_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= PORT_IF;
      wait_cnt   <= '0;
      stb        <= 1'b0;
      acc        <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      bus_err    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      wait_cnt   <= wait_cnt_nxt;
      stb        <= stb_nxt;
      acc        <= acc_nxt;
      if_ready   <= if_ready_nxt;
      d_ready    <= d_ready_nxt;
      bus_err    <= bus_err_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
    end
  end

  assign bus.m_cyc       = stb;
  assign bus.m_stb       = stb;
  assign bus.m_we        = acc.we;
  assign bus.m_sel       = acc.sel;
  assign bus.m_addr      = acc.addr;
  assign bus.m_wdata     = acc.wdata;
  assign bus.if_ready    = if_ready;
  assign bus.if_rdata    = if_rdata;
  assign bus.d_ready     = d_ready;
  assign bus.d_rdata     = d_rdata;
  assign bus.bus_err     = bus_err;
  assign bus.stallreq_if = if_pend;
  assign bus.stallreq_d  = d_pend;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: two requester drivers, a wait-state bus responder,
// and a transaction-level model that predicts grant order, strobe length and responses.
module tb_mem_bus_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int SW       = DW / 8;
  localparam int MAX_WAIT = 4;
  localparam int NTX      = 120;
  localparam int NO_ACK   = 99;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          we;
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
  } txn_t;

  txn_t if_q[$];
  txn_t d_q[$];
  int   lat_of[logic [AW-1:0]];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
  endfunction

  // Bus responder: acks a granted access after the latency recorded for its address,
  // and throws spurious acks with garbage data while the bus is idle.
  initial begin
    int   idx;
    logic prev_stb;
    idx = 0;
    prev_stb = 1'b0;
    bus.m_ack = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.m_stb) begin
        idx = prev_stb ? idx + 1 : 0;
        if (lat_of.exists(bus.m_addr) && idx == lat_of[bus.m_addr]) begin
          bus.m_ack = 1'b1;
          bus.m_rdata = pattern(bus.m_addr);
        end else begin
          bus.m_ack = 1'b0;
          bus.m_rdata = $urandom;
        end
      end else begin
        bus.m_ack = ($urandom_range(0, 7) == 0);
        bus.m_rdata = $urandom;
      end
      prev_stb = bus.m_stb;
    end
  end

  // Reference model: one access at a time; a decision in an idle cycle opens a strobe
  // next cycle lasting min(lat+1, MAX_WAIT) cycles, followed by the owner's ready cycle.
  bit   busy = 1'b0;
  bit   grant_valid = 1'b0;
  int   grant_port = 0;
  int   last_owner = 0;
  int   owner = 0;
  int   k = 0;
  int   len = 0;
  txn_t cur;

  always @(negedge clk) begin
    if (mon_en) begin
      bit            e_stb, e_ifr, e_dr, e_err, if_w, d_w;
      logic [DW-1:0] e_rdata;
      e_stb = 1'b0; e_ifr = 1'b0; e_dr = 1'b0; e_err = 1'b0; e_rdata = '0;
      if (!busy && grant_valid) begin
        grant_valid = 1'b0;
        if ((grant_port == 1 && d_q.size() > 0) || (grant_port == 0 && if_q.size() > 0)) begin
          busy = 1'b1;
          k = 0;
          owner = grant_port;
          cur = (owner == 1) ? d_q[0] : if_q[0];
          len = (cur.lat < MAX_WAIT) ? cur.lat + 1 : MAX_WAIT;
        end
      end
      if (busy) begin
        if (k < len) begin
          e_stb = 1'b1;
          check("m_addr", bus.m_addr, cur.addr);
          check("m_we", bus.m_we, cur.we);
          check("m_sel", bus.m_sel, cur.sel);
          if (cur.we) check("m_wdata", bus.m_wdata, cur.wdata);
        end else begin
          busy = 1'b0;
          e_err = (cur.lat >= MAX_WAIT);
          e_rdata = (e_err || cur.we) ? '0 : pattern(cur.addr);
          if (owner == 1) begin
            e_dr = 1'b1;
            check("d_rdata", bus.d_rdata, e_rdata);
            void'(d_q.pop_front());
          end else begin
            e_ifr = 1'b1;
            check("if_rdata", bus.if_rdata, e_rdata);
            void'(if_q.pop_front());
          end
        end
        k++;
      end
      check("m_stb", bus.m_stb, e_stb);
      check("m_cyc", bus.m_cyc, e_stb);
      check("if_ready", bus.if_ready, e_ifr);
      check("d_ready", bus.d_ready, e_dr);
      check("bus_err", bus.bus_err, e_err);
      check("stallreq_if", bus.stallreq_if, bus.if_req & ~e_ifr);
      check("stallreq_d", bus.stallreq_d, bus.d_req & ~e_dr);
      if (!busy) begin
        if_w = (if_q.size() > 0);
        d_w = (d_q.size() > 0);
        if (d_w && !(if_w && last_owner == 1)) begin
          grant_valid = 1'b1; grant_port = 1; last_owner = 1;
        end else if (if_w) begin
          grant_valid = 1'b1; grant_port = 0; last_owner = 0;
        end
      end
    end
  end

  task automatic drive_port(input bit is_d, input int n);
    for (int i = 0; i < n; i++) begin
      txn_t t;
      int   gap, r, w;
      bit   withdraw;
      gap = (i < 2) ? 0 : $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      r = $urandom_range(0, 7);
      t.lat   = (r < 6) ? (r % 4) : NO_ACK;
      t.addr  = (is_d ? 32'hD000_0000 : 32'h1000_0000) | (i << 2);
      t.we    = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      t.sel   = is_d ? SW'($urandom_range(1, (1 << SW) - 1)) : '1;
      t.wdata = is_d ? DW'($urandom) : '0;
      withdraw = ($urandom_range(0, 5) == 0);
      lat_of[t.addr] = t.lat;
      if (is_d) begin
        d_q.push_back(t);
        bus.d_req = 1'b1; bus.d_we = t.we; bus.d_sel = t.sel;
        bus.d_addr = t.addr; bus.d_wdata = t.wdata;
      end else begin
        if_q.push_back(t);
        bus.if_req = 1'b1; bus.if_addr = t.addr;
      end
      w = 0;
      while (((is_d ? d_q.size() : if_q.size()) != 0) && w < 60) begin
        @(posedge clk); #1;
        w++;
        if (withdraw && bus.m_stb && bus.m_addr == t.addr) begin
          if (is_d) bus.d_req = 1'b0; else bus.if_req = 1'b0;
        end
      end
      check(is_d ? "d_done" : "if_done", (is_d ? d_q.size() : if_q.size()) == 0, 1'b1);
      if (is_d) bus.d_req = 1'b0; else bus.if_req = 1'b0;
      if (w >= 60) begin
        if (is_d) d_q.delete(); else if_q.delete();
        return;
      end
    end
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_sel = '0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_stb", bus.m_stb, 1'b0);
    check("rst_if_ready", bus.if_ready, 1'b0);
    check("rst_d_ready", bus.d_ready, 1'b0);
    check("rst_bus_err", bus.bus_err, 1'b0);
    check("rst_m_addr", bus.m_addr, '0);
    rst = 1'b1;

    // Async reset in the middle of a data write access.
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_sel = 4'b0011;
    bus.d_addr = 32'h40; bus.d_wdata = 32'h1234;
    @(posedge clk); #1;
    check("grant_m_stb", bus.m_stb, 1'b1);
    check("grant_m_addr", bus.m_addr, 32'h40);
    check("grant_m_sel", bus.m_sel, 4'b0011);
    #2 rst = 1'b0;
    #1;
    check("async_m_stb", bus.m_stb, 1'b0);
    check("async_m_cyc", bus.m_cyc, 1'b0);
    check("async_d_ready", bus.d_ready, 1'b0);
    check("async_bus_err", bus.bus_err, 1'b0);
    check("async_stallreq_d", bus.stallreq_d, 1'b1);
    bus.d_req = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", bus.m_stb, 1'b0);
    check("post_rst_no_ready", bus.d_ready, 1'b0);

    mon_en = 1'b1;
    @(posedge clk); #1;
    fork
      drive_port(1'b0, NTX);
      drive_port(1'b1, NTX);
    join
    repeat (4) @(posedge clk);
    #1;
    check("final_idle", bus.m_stb, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
